// File: rtl/issue_dispatch_buffer_pkg.sv
// Shared types for the issue/dispatch buffer: RS->IS and IS->EX packets,
// functional-unit classes and the classification helper.
package issue_dispatch_buffer_pkg;

    localparam int          ISQ_DEPTH_DEF = 8;
    localparam logic [31:0] NOP_INST      = 32'h0000_0013;
    localparam logic [4:0]  ZERO_REG      = 5'd0;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLT    = 5'd2,
        ALU_SLTU   = 5'd3,
        ALU_AND    = 5'd4,
        ALU_OR     = 5'd5,
        ALU_XOR    = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13
    } ALU_FUNC;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_LSU  = 2'd2
    } FU_CLASS;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] PC;
        logic [5:0]  T;
        logic [4:0]  dest_reg_idx;
        ALU_FUNC     alu_func;
        logic        rd_mem;
        logic        wr_mem;
        logic        cond_branch;
        logic        halt;
    } RS_IS_PACKET;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] PC;
        logic [5:0]  T;
        logic [4:0]  dest_reg_idx;
        ALU_FUNC     alu_func;
        logic        rd_mem;
        logic        wr_mem;
        logic        cond_branch;
        logic        halt;
    } IS_EX_PACKET;

    // Memory ops win over the ALU function field, so a load/store never lands on the multiplier.
    function automatic FU_CLASS fu_classify(input RS_IS_PACKET p);
        FU_CLASS c;
        c = FU_ALU;
        if (p.rd_mem || p.wr_mem) begin
            c = FU_LSU;
        end else begin
            case (p.alu_func)
                ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: c = FU_MULT;
                default:                                  c = FU_ALU;
            endcase
        end
        return c;
    endfunction

    function automatic IS_EX_PACKET ex_nop();
        IS_EX_PACKET p;
        p              = '0;
        p.inst         = NOP_INST;
        p.dest_reg_idx = ZERO_REG;
        p.alu_func     = ALU_ADD;
        return p;
    endfunction

    function automatic IS_EX_PACKET to_ex(input RS_IS_PACKET p);
        IS_EX_PACKET e;
        e       = IS_EX_PACKET'(p);
        e.valid = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/issue_dispatch_buffer_isq_fifo.sv
// In-order holding queue: compacts up to three live lanes per cycle at the
// tail, exposes the three oldest entries, and reports a saturating free count.
module issue_dispatch_buffer_isq_fifo
    import issue_dispatch_buffer_pkg::*;
#(
    parameter int DEPTH = ISQ_DEPTH_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              squash_i,
    input  RS_IS_PACKET [2:0] pkt_i,
    input  logic [1:0]        deq_cnt_i,
    output RS_IS_PACKET [2:0] head_pkts_o,
    output logic [CW-1:0]     count_o,
    output logic [1:0]        free_num_o,
    output logic              overflow_err_o
);

    RS_IS_PACKET   mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic [CW-1:0] free_cnt;
    logic [1:0]    enq_n_d;
    logic          drop_d;
    logic [2:0]    lane_en_d;
    logic [PW-1:0] lane_ptr_d [3];

    assign free_cnt = CW'(DEPTH) - count_q;

    // Capacity is judged against the pre-dispatch count, so a full queue drops
    // new lanes even if the head drains on the same edge.
    always_comb begin
        enq_n_d   = 2'd0;
        drop_d    = 1'b0;
        lane_en_d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            lane_ptr_d[i] = tail_q + PW'(enq_n_d);
            if (pkt_i[i].valid) begin
                if (CW'(enq_n_d) < free_cnt) begin
                    lane_en_d[i] = 1'b1;
                    enq_n_d      = enq_n_d + 2'd1;
                end else begin
                    drop_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!(reset || squash_i)) begin
            for (int i = 0; i < 3; i++) begin
                if (lane_en_d[i]) begin
                    mem_q[lane_ptr_d[i]] <= pkt_i[i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || squash_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(deq_cnt_i);
            tail_q  <= tail_q + PW'(enq_n_d);
            count_q <= count_q + CW'(enq_n_d) - CW'(deq_cnt_i);
        end
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (!squash_i && drop_d) begin
            overflow_q <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_head
            assign head_pkts_o[gi] = mem_q[head_q + PW'(gi)];
        end
    endgenerate

    assign count_o        = count_q;
    assign free_num_o     = (free_cnt >= CW'(3)) ? 2'd3 : free_cnt[1:0];
    assign overflow_err_o = overflow_q;

endmodule

// File: rtl/issue_dispatch_buffer.sv
// IS stage: buffers RS packets and dispatches them strictly in order to
// three ALU lanes, one multiplier and one ready-gated LSU through the IS/EX register.
module issue_dispatch_buffer
    import issue_dispatch_buffer_pkg::*;
#(
    parameter int ISQ_DEPTH = ISQ_DEPTH_DEF,
    parameter int ALU_LANES = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash_flag,
    input  RS_IS_PACKET [2:0]             is_packet_in,
    input  logic                          lsu_ready,
    output IS_EX_PACKET [ALU_LANES-1:0]   alu_packet_out,
    output IS_EX_PACKET                   mult_packet_out,
    output IS_EX_PACKET                   lsu_packet_out,
    output logic [1:0]                    free_num,
    output logic                          overflow_err
);

    localparam int CW = $clog2(ISQ_DEPTH) + 1;
    localparam int AW = $clog2(ALU_LANES + 1);

    generate
        if ((ISQ_DEPTH < 4) || ((ISQ_DEPTH & (ISQ_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("ISQ_DEPTH must be a power of 2 and at least 4");
        end
    endgenerate

    RS_IS_PACKET [2:0]           head_pkts;
    logic [CW-1:0]               count;
    logic [1:0]                  deq_cnt_d;

    IS_EX_PACKET [ALU_LANES-1:0] alu_d, alu_q;
    IS_EX_PACKET                 mult_d, mult_q;
    IS_EX_PACKET                 lsu_d, lsu_q;

    logic [AW-1:0]               alu_n_d;
    logic                        mult_taken_d, lsu_taken_d, blocked_d, take_d;

    issue_dispatch_buffer_isq_fifo #(
        .DEPTH (ISQ_DEPTH)
    ) u_fifo (
        .clock          (clock),
        .reset          (reset),
        .squash_i       (squash_flag),
        .pkt_i          (is_packet_in),
        .deq_cnt_i      (deq_cnt_d),
        .head_pkts_o    (head_pkts),
        .count_o        (count),
        .free_num_o     (free_num),
        .overflow_err_o (overflow_err)
    );

    // Walk the three oldest entries; the first one without a free unit stops
    // the walk so nothing younger overtakes it.
    always_comb begin
        for (int k = 0; k < ALU_LANES; k++) begin
            alu_d[k] = ex_nop();
        end
        mult_d       = ex_nop();
        lsu_d        = ex_nop();
        deq_cnt_d    = 2'd0;
        alu_n_d      = '0;
        mult_taken_d = 1'b0;
        lsu_taken_d  = 1'b0;
        blocked_d    = 1'b0;
        take_d       = 1'b0;
        for (int j = 0; j < 3; j++) begin
            take_d = 1'b0;
            if (!blocked_d && (CW'(j) < count)) begin
                case (fu_classify(head_pkts[j]))
                    FU_ALU: begin
                        if (int'(alu_n_d) < ALU_LANES) begin
                            alu_d[alu_n_d] = to_ex(head_pkts[j]);
                            alu_n_d        = alu_n_d + AW'(1);
                            take_d         = 1'b1;
                        end
                    end
                    FU_MULT: begin
                        if (!mult_taken_d) begin
                            mult_d       = to_ex(head_pkts[j]);
                            mult_taken_d = 1'b1;
                            take_d       = 1'b1;
                        end
                    end
                    FU_LSU: begin
                        if (!lsu_taken_d && lsu_ready) begin
                            lsu_d       = to_ex(head_pkts[j]);
                            lsu_taken_d = 1'b1;
                            take_d      = 1'b1;
                        end
                    end
                    default: take_d = 1'b0;
                endcase
            end
            if (take_d) begin
                deq_cnt_d = deq_cnt_d + 2'd1;
            end else begin
                blocked_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || squash_flag) begin
            for (int k = 0; k < ALU_LANES; k++) begin
                alu_q[k] <= ex_nop();
            end
            mult_q <= ex_nop();
            lsu_q  <= ex_nop();
        end else begin
            alu_q  <= alu_d;
            mult_q <= mult_d;
            lsu_q  <= lsu_d;
        end
    end

    assign alu_packet_out  = alu_q;
    assign mult_packet_out = mult_q;
    assign lsu_packet_out  = lsu_q;

endmodule

// File: tb/tb_issue_dispatch_buffer.sv
// Self-checking bench for issue_dispatch_buffer: directed vector table, hand
// sequences for overflow/squash/wrap, and random traffic against a queue model.
module tb_issue_dispatch_buffer;
    import issue_dispatch_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              squash_flag = 1'b0;
    logic              lsu_ready = 1'b0;
    RS_IS_PACKET [2:0] is_packet_in = '0;
    IS_EX_PACKET [2:0] alu_packet_out;
    IS_EX_PACKET       mult_packet_out;
    IS_EX_PACKET       lsu_packet_out;
    logic [1:0]        free_num;
    logic              overflow_err;

    int n_checks = 0;
    int n_errors = 0;
    int tag_ctr  = 0;

    RS_IS_PACKET mq[$];
    bit          m_ovf;
    IS_EX_PACKET m_alu [3];
    IS_EX_PACKET m_mult, m_lsu;

    ALU_FUNC plain_ops [6] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SRA};
    ALU_FUNC mul_ops   [4] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};

    issue_dispatch_buffer #(
        .ISQ_DEPTH (DEPTH),
        .ALU_LANES (3)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .squash_flag     (squash_flag),
        .is_packet_in    (is_packet_in),
        .lsu_ready       (lsu_ready),
        .alu_packet_out  (alu_packet_out),
        .mult_packet_out (mult_packet_out),
        .lsu_packet_out  (lsu_packet_out),
        .free_num        (free_num),
        .overflow_err    (overflow_err)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic IS_EX_PACKET nop_pkt();
        IS_EX_PACKET p;
        p          = '0;
        p.inst     = 32'h0000_0013;
        p.alu_func = ALU_ADD;
        return p;
    endfunction

    // 1 = ALU, 2 = MULT, 3 = LSU
    function automatic int kind_of(input RS_IS_PACKET p);
        if (p.rd_mem || p.wr_mem) return 3;
        if (p.alu_func inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU}) return 2;
        return 1;
    endfunction

    function automatic IS_EX_PACKET as_ex(input RS_IS_PACKET p);
        IS_EX_PACKET e;
        e       = IS_EX_PACKET'(p);
        e.valid = 1'b1;
        return e;
    endfunction

    // kind 0 builds a dead lane with random contents, others a live packet with the next tag
    function automatic RS_IS_PACKET mk(input int kind);
        RS_IS_PACKET p;
        p              = '0;
        p.inst         = $urandom;
        p.PC           = $urandom;
        p.dest_reg_idx = 5'($urandom);
        p.valid        = (kind != 0);
        p.T            = 6'(tag_ctr);
        case (kind)
            2: p.alu_func = mul_ops[$urandom_range(0, 3)];
            3: begin
                p.alu_func = plain_ops[$urandom_range(0, 5)];
                if ($urandom_range(0, 1) == 1) p.rd_mem = 1'b1;
                else                           p.wr_mem = 1'b1;
            end
            1: begin
                p.alu_func    = plain_ops[$urandom_range(0, 5)];
                p.cond_branch = 1'($urandom_range(0, 1));
            end
            default: begin
                p.alu_func = mul_ops[$urandom_range(0, 3)];
                p.rd_mem   = 1'($urandom_range(0, 1));
            end
        endcase
        if (kind != 0) tag_ctr++;
        return p;
    endfunction

    task automatic model_edge(input RS_IS_PACKET [2:0] pk, input logic rdy, input logic sq, input logic rst);
        RS_IS_PACKET acc[$];
        int n_alu, nd, room;
        bit mu, ls, ok;
        for (int k = 0; k < 3; k++) m_alu[k] = nop_pkt();
        m_mult = nop_pkt();
        m_lsu  = nop_pkt();
        if (rst || sq) begin
            mq.delete();
            if (rst) m_ovf = 1'b0;
            return;
        end
        n_alu = 0; nd = 0; mu = 1'b0; ls = 1'b0;
        for (int i = 0; i < 3 && i < mq.size(); i++) begin
            ok = 1'b0;
            case (kind_of(mq[i]))
                1: if (n_alu < 3) begin m_alu[n_alu] = as_ex(mq[i]); n_alu++; ok = 1'b1; end
                2: if (!mu) begin m_mult = as_ex(mq[i]); mu = 1'b1; ok = 1'b1; end
                3: if (!ls && rdy) begin m_lsu = as_ex(mq[i]); ls = 1'b1; ok = 1'b1; end
                default: ok = 1'b0;
            endcase
            if (!ok) break;
            nd++;
        end
        room = DEPTH - mq.size();
        for (int k = 0; k < 3; k++) begin
            if (pk[k].valid) begin
                if (acc.size() < room) acc.push_back(pk[k]);
                else                   m_ovf = 1'b1;
            end
        end
        repeat (nd) void'(mq.pop_front());
        foreach (acc[k]) mq.push_back(acc[k]);
    endtask

    task automatic model_check();
        int exp_free;
        exp_free = DEPTH - mq.size();
        if (exp_free > 3) exp_free = 3;
        for (int k = 0; k < 3; k++)
            check($sformatf("model.alu%0d", k), 128'(alu_packet_out[k]), 128'(m_alu[k]));
        check("model.mult", 128'(mult_packet_out), 128'(m_mult));
        check("model.lsu", 128'(lsu_packet_out), 128'(m_lsu));
        check("model.free_num", 128'(free_num), 128'(exp_free));
        check("model.overflow_err", 128'(overflow_err), 128'(m_ovf));
    endtask

    task automatic cycle(input int k0, input int k1, input int k2,
                         input logic rdy, input logic sq, input logic rst);
        RS_IS_PACKET [2:0] pk;
        pk[0] = mk(k0);
        pk[1] = mk(k1);
        pk[2] = mk(k2);
        is_packet_in = pk;
        lsu_ready    = rdy;
        squash_flag  = sq;
        reset        = rst;
        @(posedge clock);
        model_edge(pk, rdy, sq, rst);
        #1;
        model_check();
    endtask

    function automatic logic [4:0] all_valids();
        return {lsu_packet_out.valid, mult_packet_out.valid, alu_packet_out[2].valid,
                alu_packet_out[1].valid, alu_packet_out[0].valid};
    endfunction

    typedef struct {
        int         k0, k1, k2;
        logic       rdy;
        logic [2:0] exp_alu_v;
        int         exp_t0, exp_t1, exp_t2;
        logic       exp_mult_v;
        int         exp_mult_t;
        logic       exp_lsu_v;
        int         exp_lsu_t;
        logic [1:0] exp_free;
    } vec_t;

    vec_t tbl [12];
    int   got[$];

    initial begin
        // 3 ALU in order, 2 MULTs back to back, LSU head blocking an ALU for three cycles
        tbl[0]  = '{1, 1, 1, 1'b1, 3'b000, -1, -1, -1, 1'b0, -1, 1'b0, -1, 2'd3};
        tbl[1]  = '{0, 0, 0, 1'b1, 3'b111,  1,  2,  3, 1'b0, -1, 1'b0, -1, 2'd3};
        tbl[2]  = '{2, 2, 0, 1'b1, 3'b000, -1, -1, -1, 1'b0, -1, 1'b0, -1, 2'd3};
        tbl[3]  = '{0, 0, 0, 1'b1, 3'b000, -1, -1, -1, 1'b1,  4, 1'b0, -1, 2'd3};
        tbl[4]  = '{0, 0, 0, 1'b1, 3'b000, -1, -1, -1, 1'b1,  5, 1'b0, -1, 2'd3};
        tbl[5]  = '{0, 0, 0, 1'b1, 3'b000, -1, -1, -1, 1'b0, -1, 1'b0, -1, 2'd3};
        tbl[6]  = '{3, 1, 0, 1'b0, 3'b000, -1, -1, -1, 1'b0, -1, 1'b0, -1, 2'd3};
        tbl[7]  = '{0, 0, 0, 1'b0, 3'b000, -1, -1, -1, 1'b0, -1, 1'b0, -1, 2'd3};
        tbl[8]  = '{0, 0, 0, 1'b0, 3'b000, -1, -1, -1, 1'b0, -1, 1'b0, -1, 2'd3};
        tbl[9]  = '{0, 0, 0, 1'b0, 3'b000, -1, -1, -1, 1'b0, -1, 1'b0, -1, 2'd3};
        tbl[10] = '{0, 0, 0, 1'b1, 3'b001,  7, -1, -1, 1'b0, -1, 1'b1,  6, 2'd3};
        tbl[11] = '{0, 0, 0, 1'b1, 3'b000, -1, -1, -1, 1'b0, -1, 1'b0, -1, 2'd3};

        // reset state
        cycle(0, 0, 0, 1'b0, 1'b0, 1'b1);
        cycle(0, 0, 0, 1'b0, 1'b0, 1'b1);
        check("reset.free_num", 128'(free_num), 128'(3));
        check("reset.overflow_err", 128'(overflow_err), 128'(0));
        check("reset.valids", 128'(all_valids()), 128'(0));
        check("reset.alu0_nop", 128'(alu_packet_out[0]), 128'(nop_pkt()));

        tag_ctr = 1;
        for (int v = 0; v < 12; v++) begin
            cycle(tbl[v].k0, tbl[v].k1, tbl[v].k2, tbl[v].rdy, 1'b0, 1'b0);
            check($sformatf("tbl%0d.alu_v", v),
                  128'({alu_packet_out[2].valid, alu_packet_out[1].valid, alu_packet_out[0].valid}),
                  128'(tbl[v].exp_alu_v));
            if (tbl[v].exp_t0 >= 0) check($sformatf("tbl%0d.alu0_T", v), 128'(alu_packet_out[0].T), 128'(tbl[v].exp_t0));
            if (tbl[v].exp_t1 >= 0) check($sformatf("tbl%0d.alu1_T", v), 128'(alu_packet_out[1].T), 128'(tbl[v].exp_t1));
            if (tbl[v].exp_t2 >= 0) check($sformatf("tbl%0d.alu2_T", v), 128'(alu_packet_out[2].T), 128'(tbl[v].exp_t2));
            check($sformatf("tbl%0d.mult_v", v), 128'(mult_packet_out.valid), 128'(tbl[v].exp_mult_v));
            if (tbl[v].exp_mult_t >= 0) check($sformatf("tbl%0d.mult_T", v), 128'(mult_packet_out.T), 128'(tbl[v].exp_mult_t));
            check($sformatf("tbl%0d.lsu_v", v), 128'(lsu_packet_out.valid), 128'(tbl[v].exp_lsu_v));
            if (tbl[v].exp_lsu_t >= 0) check($sformatf("tbl%0d.lsu_T", v), 128'(lsu_packet_out.T), 128'(tbl[v].exp_lsu_t));
            check($sformatf("tbl%0d.free_num", v), 128'(free_num), 128'(tbl[v].exp_free));
        end

        // fill to DEPTH behind a stalled LSU, then overflow by one
        cycle(0, 0, 0, 1'b0, 1'b0, 1'b1);
        cycle(3, 1, 1, 1'b0, 1'b0, 1'b0);
        cycle(1, 1, 1, 1'b0, 1'b0, 1'b0);
        check("fill.free_num_6", 128'(free_num), 128'(2));
        cycle(1, 1, 0, 1'b0, 1'b0, 1'b0);
        check("fill.free_num_8", 128'(free_num), 128'(0));
        check("fill.no_ovf_yet", 128'(overflow_err), 128'(0));
        cycle(1, 0, 0, 1'b0, 1'b0, 1'b0);
        check("fill.ovf_set", 128'(overflow_err), 128'(1));
        for (int c = 0; c < 6; c++) begin
            cycle(0, 0, 0, 1'b1, 1'b0, 1'b0);
            check($sformatf("fill.ovf_sticky%0d", c), 128'(overflow_err), 128'(1));
        end
        check("fill.drained_free", 128'(free_num), 128'(3));
        cycle(0, 0, 0, 1'b1, 1'b1, 1'b0);
        check("fill.ovf_survives_squash", 128'(overflow_err), 128'(1));
        cycle(0, 0, 0, 1'b1, 1'b0, 1'b1);
        check("fill.ovf_cleared_by_reset", 128'(overflow_err), 128'(0));

        // squash with five held entries and three live inputs
        cycle(3, 1, 1, 1'b0, 1'b0, 1'b0);
        cycle(1, 1, 0, 1'b0, 1'b0, 1'b0);
        tag_ctr = 60;
        cycle(1, 1, 1, 1'b0, 1'b1, 1'b0);
        check("squash.free_num", 128'(free_num), 128'(3));
        check("squash.valids", 128'(all_valids()), 128'(0));
        for (int c = 0; c < 5; c++) begin
            cycle(0, 0, 0, 1'b1, 1'b0, 1'b0);
            check($sformatf("squash.quiet%0d", c), 128'(all_valids()), 128'(0));
        end

        // 20 ALU packets, two per cycle, must emerge once each and in order
        tag_ctr = 0;
        got.delete();
        for (int c = 0; c < 14; c++) begin
            if (c < 10) cycle(1, 1, 0, 1'b1, 1'b0, 1'b0);
            else        cycle(0, 0, 0, 1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++)
                if (alu_packet_out[k].valid) got.push_back(int'(alu_packet_out[k].T));
        end
        check("wrap.count", 128'(got.size()), 128'(20));
        for (int i = 0; i < got.size() && i < 20; i++)
            check($sformatf("wrap.order%0d", i), 128'(got[i]), 128'(i));

        // random traffic against the queue model
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 49) == 0),
                  1'($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
